// File: rtl/noc_output_port_arbiter.sv
// noc_output_port_arbiter: round-robin output-port arbiter with one buffer per VC, filling one VC and draining the other each cycle.
// Define NOC_ARB_STATS_EN to add saturating per-requester grant counters (stat_sel/stat_cnt).
module noc_output_port_arbiter #(
  parameter int PACKET_WIDTH = 64,
  parameter int NUM_REQ = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [0:NUM_REQ-1]                req,
  input  logic [0:NUM_REQ*PACKET_WIDTH-1]   req_data,
  output logic [0:NUM_REQ-1]                gnt,
  input  logic                              polarity,
  output logic                              out_so,
  input  logic                              out_ro,
  output logic [0:PACKET_WIDTH-1]           out_do
`ifdef NOC_ARB_STATS_EN
  ,
  input  logic [$clog2(NUM_REQ)-1:0]        stat_sel,
  output logic [15:0]                       stat_cnt
`endif
);
  localparam int PW = $clog2(NUM_REQ);
  logic                    f, l, hit;
  logic [0:1]              buf_full;
  logic [0:PACKET_WIDTH-1] buf_data [0:1];
  logic [PW-1:0]           rr_ptr [0:1];
  logic [PW-1:0]           win;
  logic [0:NUM_REQ-1]      elig;
  logic [0:PACKET_WIDTH-1] pkt;
  int                      idx;
  assign f = ~polarity;
  assign l = polarity;
  assign pkt = req_data[win*PACKET_WIDTH +: PACKET_WIDTH];
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = req[i] && (req_data[i*PACKET_WIDTH] == f) && !buf_full[f];
  end
  // scan downward so the nearest eligible requester at/after the pointer wins last
  always_comb begin
    win = '0;
    hit = 1'b0;
    idx = 0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      idx = int'(rr_ptr[f]) + k;
      idx = idx >= NUM_REQ ? idx - NUM_REQ : idx;
      if (elig[idx]) begin
        win = PW'(idx);
        hit = 1'b1;
      end
    end
  end
  always_comb begin
    gnt = '0;
    if (hit && reset) gnt[win] = 1'b1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_full <= '0;
      buf_data <= '{default: '0};
      rr_ptr   <= '{default: '0};
      out_so   <= 1'b0;
      out_do   <= '0;
    end else begin
      if (hit) begin
        buf_data[f] <= pkt;
        buf_full[f] <= 1'b1;
        rr_ptr[f]   <= win == PW'(NUM_REQ-1) ? '0 : win + 1'b1;
      end
      if (buf_full[l] && out_ro) begin
        out_so      <= 1'b1;
        out_do      <= buf_data[l];
        buf_full[l] <= 1'b0;
      end else
        out_so <= 1'b0;
    end
  end
`ifdef NOC_ARB_STATS_EN
  logic [15:0] cnt [0:NUM_REQ-1];
  assign stat_cnt = cnt[stat_sel];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '{default: '0};
    else if (hit && cnt[win] != 16'hFFFF)
      cnt[win] <= cnt[win] + 16'd1;
  end
`endif
endmodule
